// File: rtl/game_pkg.sv
// Shared game constants and the collision FSM state encoding.
package game_pkg;

  localparam int TILE_SIZE      = 32;
  localparam int H_VISIBLE_AREA = 640;
  localparam int MAX_CARS       = 4;

  localparam int LANE_ROW_0 = 3;
  localparam int LANE_ROW_1 = 5;
  localparam int LANE_ROW_2 = 7;
  localparam int LANE_ROW_3 = 9;

  typedef enum logic [1:0] {
    STATE_ALIVE     = 2'd0,
    STATE_GRACE     = 2'd1,
    STATE_GAME_OVER = 2'd2
  } state_e;

endpackage

// File: rtl/collision_monitor_if.sv
// Bus between the game logic and the collision monitor; o_State is the FSM debug view.
interface collision_monitor_if;

  // No handshake: every i_ signal is sampled on each rising clock edge and
  // every o_ signal is a registered level or a single-cycle pulse.
  logic [9:0] i_Car_X_0;
  logic [9:0] i_Car_X_1;
  logic [9:0] i_Car_X_2;
  logic [9:0] i_Car_X_3;
  logic [9:0] i_Frog_X;
  logic [3:0] i_Frog_Row;
  logic       i_Restart;

  logic       o_Hit;
  logic [1:0] o_Hit_Car;
  logic       o_Respawn;
  logic [1:0] o_Lives;
  logic       o_Game_Over;
  logic       o_Invuln;
  logic [1:0] o_State;

  modport master (
    output i_Car_X_0, i_Car_X_1, i_Car_X_2, i_Car_X_3,
    output i_Frog_X, i_Frog_Row, i_Restart,
    input  o_Hit, o_Hit_Car, o_Respawn, o_Lives, o_Game_Over, o_Invuln, o_State
  );

  modport slave (
    input  i_Car_X_0, i_Car_X_1, i_Car_X_2, i_Car_X_3,
    input  i_Frog_X, i_Frog_Row, i_Restart,
    output o_Hit, o_Hit_Car, o_Respawn, o_Lives, o_Game_Over, o_Invuln, o_State
  );

endinterface

// File: rtl/lane_overlap.sv
// Combinational frog/car overlap test for one lane, done at 11 bits so X + TILE_SIZE never wraps.
module lane_overlap #(
  parameter int         TILE_SIZE = 32,
  parameter logic [3:0] LANE_ROW  = 4'd3,
  parameter bit         ENABLE    = 1'b1
) (
  input  logic [9:0] car_x,
  input  logic [9:0] frog_x,
  input  logic [3:0] frog_row,
  output logic       overlap
);

  logic [10:0] car_w;
  logic [10:0] frog_w;

  always_comb begin
    car_w   = {1'b0, car_x};
    frog_w  = {1'b0, frog_x};
    overlap = ENABLE
              && (frog_row == LANE_ROW)
              && (frog_w < car_w + 11'(TILE_SIZE))
              && (car_w < frog_w + 11'(TILE_SIZE));
  end

endmodule

// File: rtl/collision_monitor.sv
// Frog/car collision monitor: lives, respawn and game-over tracking.
// Define COLLISION_GRACE_EN to build the post-hit invulnerability (GRACE) state.
module collision_monitor #(
  parameter int c_NB_CARS      = 1,
  parameter int TILE_SIZE      = game_pkg::TILE_SIZE,
  parameter int c_LANE_ROW_0   = game_pkg::LANE_ROW_0,
  parameter int c_LANE_ROW_1   = game_pkg::LANE_ROW_1,
  parameter int c_LANE_ROW_2   = game_pkg::LANE_ROW_2,
  parameter int c_LANE_ROW_3   = game_pkg::LANE_ROW_3,
  parameter int c_START_LIVES  = 3,
  parameter int c_GRACE_CYCLES = 25000000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  collision_monitor_if.slave bus
);

  import game_pkg::*;

  localparam logic [1:0] S_ALIVE     = STATE_ALIVE;
  localparam logic [1:0] S_GAME_OVER = STATE_GAME_OVER;
  localparam logic [3:0] LANE_ROWS [MAX_CARS] = '{
    4'(c_LANE_ROW_0), 4'(c_LANE_ROW_1), 4'(c_LANE_ROW_2), 4'(c_LANE_ROW_3)
  };

  logic [9:0]          car_x_q [MAX_CARS];
  logic [9:0]          frog_x_q;
  logic [3:0]          frog_row_q;
  logic [MAX_CARS-1:0] overlap;
  logic                any_overlap;
  logic [1:0]          first_car;

  logic [1:0] state;
  logic [1:0] lives;
  logic       hit;
  logic       respawn;
  logic [1:0] hit_car;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int k = 0; k < MAX_CARS; k++) car_x_q[k] <= '0;
      frog_x_q   <= '0;
      frog_row_q <= '0;
    end else begin
      car_x_q[0] <= bus.i_Car_X_0;
      car_x_q[1] <= bus.i_Car_X_1;
      car_x_q[2] <= bus.i_Car_X_2;
      car_x_q[3] <= bus.i_Car_X_3;
      frog_x_q   <= bus.i_Frog_X;
      frog_row_q <= bus.i_Frog_Row;
    end
  end

  for (genvar k = 0; k < MAX_CARS; k++) begin : g_lane
    lane_overlap #(
      .TILE_SIZE (TILE_SIZE),
      .LANE_ROW  (LANE_ROWS[k]),
      .ENABLE    (k < c_NB_CARS)
    ) u_lane (
      .car_x    (car_x_q[k]),
      .frog_x   (frog_x_q),
      .frog_row (frog_row_q),
      .overlap  (overlap[k])
    );
  end

  // Lowest-index overlapping car wins when several collide in the same cycle.
  always_comb begin
    first_car = 2'd0;
    for (int k = MAX_CARS - 1; k >= 0; k--) begin
      if (overlap[k]) first_car = 2'(k);
    end
  end

  assign any_overlap = |overlap;

`ifdef COLLISION_GRACE_EN
  localparam logic [1:0]  S_GRACE    = STATE_GRACE;
  localparam logic [24:0] GRACE_LAST = 25'(c_GRACE_CYCLES - 1);
  logic [24:0] grace_cnt;
`else
  // Grace length has no meaning without the GRACE state; this only references it.
  if (c_GRACE_CYCLES < 1) begin : g_grace_unused
  end
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= S_ALIVE;
      lives   <= 2'(c_START_LIVES);
      hit     <= 1'b0;
      respawn <= 1'b0;
      hit_car <= 2'd0;
`ifdef COLLISION_GRACE_EN
      grace_cnt <= '0;
`endif
    end else begin
      hit     <= 1'b0;
      respawn <= 1'b0;
      case (state)
        S_ALIVE: begin
          // The !hit term keeps a held overlap from producing back-to-back pulses.
          if (any_overlap && !hit) begin
            hit     <= 1'b1;
            hit_car <= first_car;
            lives   <= lives - 2'd1;
            if (lives == 2'd1) begin
              state <= S_GAME_OVER;
            end else begin
              respawn <= 1'b1;
`ifdef COLLISION_GRACE_EN
              state   <= S_GRACE;
`endif
            end
          end
        end
`ifdef COLLISION_GRACE_EN
        S_GRACE: begin
          if (grace_cnt == GRACE_LAST) begin
            grace_cnt <= '0;
            state     <= S_ALIVE;
          end else begin
            grace_cnt <= grace_cnt + 25'd1;
          end
        end
`endif
        S_GAME_OVER: begin
          if (bus.i_Restart) begin
            state <= S_ALIVE;
            lives <= 2'(c_START_LIVES);
          end
        end
        default: state <= S_ALIVE;
      endcase
    end
  end

  assign bus.o_Hit       = hit;
  assign bus.o_Hit_Car   = hit_car;
  assign bus.o_Respawn   = respawn;
  assign bus.o_Lives     = lives;
  assign bus.o_Game_Over = (state == S_GAME_OVER);
  assign bus.o_State     = state;
`ifdef COLLISION_GRACE_EN
  assign bus.o_Invuln    = (state == S_GRACE);
`else
  assign bus.o_Invuln    = 1'b0;
`endif

endmodule

// File: tb/tb_collision_monitor.sv
// Directed bench for collision_monitor: vector table plus multi-cycle sequences.
// Expectations adapt to whether COLLISION_GRACE_EN is defined for the build.
module tb_collision_monitor;

  localparam int GRACE = 10;
`ifdef COLLISION_GRACE_EN
  localparam bit GRACE_EN = 1'b1;
`else
  localparam bit GRACE_EN = 1'b0;
`endif
  // Edges between successive hits while an overlap is held.
  localparam int HIT_GAP = GRACE_EN ? GRACE + 1 : 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  collision_monitor_if bus ();

  collision_monitor #(
    .c_NB_CARS      (4),
    .TILE_SIZE      (32),
    .c_LANE_ROW_0   (3),
    .c_LANE_ROW_1   (5),
    .c_LANE_ROW_2   (7),
    .c_LANE_ROW_3   (5),
    .c_START_LIVES  (3),
    .c_GRACE_CYCLES (GRACE)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic [9:0] fx, input logic [3:0] fr,
                       input logic [9:0] c0, input logic [9:0] c1,
                       input logic [9:0] c2, input logic [9:0] c3);
    bus.i_Frog_X   = fx;
    bus.i_Frog_Row = fr;
    bus.i_Car_X_0  = c0;
    bus.i_Car_X_1  = c1;
    bus.i_Car_X_2  = c2;
    bus.i_Car_X_3  = c3;
  endtask

  task automatic do_reset();
    drive(10'd0, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0);
    bus.i_Restart = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "/hit"},       32'(bus.o_Hit),       32'd0);
    chk({tag, "/hit_car"},   32'(bus.o_Hit_Car),   32'd0);
    chk({tag, "/respawn"},   32'(bus.o_Respawn),   32'd0);
    chk({tag, "/lives"},     32'(bus.o_Lives),     32'd3);
    chk({tag, "/game_over"}, 32'(bus.o_Game_Over), 32'd0);
    chk({tag, "/invuln"},    32'(bus.o_Invuln),    32'd0);
  endtask

  typedef struct {
    string      name;
    logic [9:0] frog_x;
    logic [3:0] frog_row;
    logic [9:0] c0, c1, c2, c3;
    logic       exp_hit;
    logic [1:0] exp_car;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  // Scoreboard for the held-overlap run: expected hit cycles queued up front.
  logic [31:0] exp_q [$];

  initial begin
    int hits;
    int consec;
    logic prev_hit, prev_resp;
    logic inv11, inv12, inv_any;
    logic [1:0] hit_lives [3];
    logic       hit_resp  [3];

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.i_Restart = 1'b0;
    drive(10'd0, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0);
    @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Lanes: car0 row 3, car1 row 5, car2 row 7, car3 row 5; tile 32.
    vecs[0]  = '{"basic",      10'd100,  4'd3, 10'd80,  10'd0,   10'd0,    10'd0,   1'b1, 2'd0};
    vecs[1]  = '{"touch_lo",   10'd100,  4'd3, 10'd68,  10'd0,   10'd0,    10'd0,   1'b0, 2'd0};
    vecs[2]  = '{"overlap_lo", 10'd100,  4'd3, 10'd69,  10'd0,   10'd0,    10'd0,   1'b1, 2'd0};
    vecs[3]  = '{"touch_hi",   10'd100,  4'd3, 10'd132, 10'd0,   10'd0,    10'd0,   1'b0, 2'd0};
    vecs[4]  = '{"overlap_hi", 10'd100,  4'd3, 10'd131, 10'd0,   10'd0,    10'd0,   1'b1, 2'd0};
    vecs[5]  = '{"two_cars",   10'd200,  4'd5, 10'd0,   10'd190, 10'd0,    10'd210, 1'b1, 2'd1};
    vecs[6]  = '{"car3_only",  10'd200,  4'd5, 10'd0,   10'd0,   10'd0,    10'd220, 1'b1, 2'd3};
    vecs[7]  = '{"no_wrap",    10'd0,    4'd7, 10'd0,   10'd0,   10'd1000, 10'd0,   1'b0, 2'd0};
    vecs[8]  = '{"right_edge", 10'd1000, 4'd7, 10'd0,   10'd0,   10'd1023, 10'd0,   1'b1, 2'd2};
    vecs[9]  = '{"wrong_row",  10'd100,  4'd4, 10'd100, 10'd0,   10'd0,    10'd0,   1'b0, 2'd0};
    vecs[10] = '{"other_lane", 10'd100,  4'd3, 10'd0,   10'd100, 10'd0,    10'd0,   1'b0, 2'd0};
    vecs[11] = '{"car2_row5",  10'd300,  4'd5, 10'd0,   10'd0,   10'd300,  10'd0,   1'b0, 2'd0};

    for (int i = 0; i < NV; i++) begin
      do_reset();
      drive(vecs[i].frog_x, vecs[i].frog_row, vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "/hit"},     32'(bus.o_Hit),     32'(vecs[i].exp_hit));
      if (vecs[i].exp_hit) chk({vecs[i].name, "/hit_car"}, 32'(bus.o_Hit_Car), 32'(vecs[i].exp_car));
      chk({vecs[i].name, "/lives"},   32'(bus.o_Lives),   vecs[i].exp_hit ? 32'd2 : 32'd3);
      chk({vecs[i].name, "/respawn"}, 32'(bus.o_Respawn), 32'(vecs[i].exp_hit));
      chk({vecs[i].name, "/invuln"},  32'(bus.o_Invuln),  32'(vecs[i].exp_hit & GRACE_EN));
      drive(10'd0, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "/pulse_end"}, 32'(bus.o_Hit), 32'd0);
    end

    // Restart while not in GAME_OVER changes nothing.
    do_reset();
    drive(10'd100, 4'd3, 10'd80, 10'd0, 10'd0, 10'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    drive(10'd0, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0);
    bus.i_Restart = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Restart = 1'b0;
    chk("restart_ignored/lives",     32'(bus.o_Lives),     32'd2);
    chk("restart_ignored/game_over", 32'(bus.o_Game_Over), 32'd0);

    // Held overlap: three hits spaced by grace, then game over.
    do_reset();
    for (int k = 0; k < 3; k++) exp_q.push_back(32'(2 + k * HIT_GAP));
    drive(10'd100, 4'd3, 10'd80, 10'd0, 10'd0, 10'd0);
    hits = 0; consec = 0; prev_hit = 1'b0; prev_resp = 1'b0;
    inv11 = 1'b0; inv12 = 1'b0; inv_any = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_Hit) begin
        if (hits < 3) begin
          chk($sformatf("held/hit%0d_cycle", hits), 32'(c),
              (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
          hit_lives[hits] = bus.o_Lives;
          hit_resp[hits]  = bus.o_Respawn;
        end
        hits++;
      end
      if ((bus.o_Hit && prev_hit) || (bus.o_Respawn && prev_resp)) consec++;
      if (c == 11) inv11 = bus.o_Invuln;
      if (c == 12) inv12 = bus.o_Invuln;
      inv_any   = inv_any | bus.o_Invuln;
      prev_hit  = bus.o_Hit;
      prev_resp = bus.o_Respawn;
    end
    chk("held/hit_count",   32'(hits),   32'd3);
    chk("held/consecutive", 32'(consec), 32'd0);
    if (hits >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("held/hit%0d_lives", k),   32'(hit_lives[k]), 32'(2 - k));
        chk($sformatf("held/hit%0d_respawn", k), 32'(hit_resp[k]),  (k < 2) ? 32'd1 : 32'd0);
      end
    end
    chk("held/inv_cycle11", 32'(inv11),   32'(GRACE_EN));
    chk("held/inv_cycle12", 32'(inv12),   32'd0);
    chk("held/inv_seen",    32'(inv_any), 32'(GRACE_EN));
    chk("held/game_over",   32'(bus.o_Game_Over), 32'd1);
    chk("held/lives_zero",  32'(bus.o_Lives),     32'd0);

    bus.i_Restart = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Restart = 1'b0;
    chk("restart/lives",     32'(bus.o_Lives),     32'd3);
    chk("restart/game_over", 32'(bus.o_Game_Over), 32'd0);
    @(posedge clk);
    #1;
    chk("restart/rehit",       32'(bus.o_Hit),   32'd1);
    chk("restart/rehit_lives", 32'(bus.o_Lives), 32'd2);

    // Reset on grace cycle 5 with overlap and restart also asserted.
    do_reset();
    drive(10'd200, 4'd5, 10'd0, 10'd0, 10'd0, 10'd220);
    @(posedge clk);
    #1;
    chk("latency/edge1", 32'(bus.o_Hit), 32'd0);
    @(posedge clk);
    #1;
    chk("latency/edge2",  32'(bus.o_Hit),     32'd1);
    chk("latency/car",    32'(bus.o_Hit_Car), 32'd3);
    for (int c = 0; c < 5; c++) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.i_Restart = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_Restart = 1'b0;
    chk_reset_outputs("mid_reset");

    drive(10'd0, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
